rtc_dato_captura: RTL and testbench

Downstream companion of the RTC read sequencer. Decodes the sequencer's one-hot address strobes into the 8-bit address driven on the RTC multiplexed A/D bus. Captures the RTC data bus into shadow registers under the sequencer's per-field latch strobes. When the sequencer signals `ready`, it validates the complete frame (BCD and range) and atomically commits it to the stable time/timer outputs consumed by the display and edit logic.

---
 rtl/rtc_dato_captura.sv | 235 +++++++++++++++++++++++
 tb/tb_rtc_dato_captura.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_dato_captura.sv
// rtc_dato_captura
// Downstream companion of the RTC read sequencer.
//  - Decodes the one-hot dir_* selects into the address/command byte for the
//    RTC multiplexed A/D bus (bus_out, combinational). bus_oe follows
//    buffer_activo.
//  - Captures bus_in into per-field shadow registers while the matching
//    *_in strobe is high. A field counts as captured when its strobe falls.
//  - On the rising edge of ready, validates the whole frame and commits it
//    atomically to the field outputs. On a commit, valido is set and
//    actualizado pulses. A rejected frame pulses error instead.
// Ports: clk, reset (async, active-high), bus_in/bus_out/bus_oe/buffer_activo
//   (A/D bus), dir_* (address selects), *_in (data strobes), ready (frame
//   complete level), seg..thora (committed BCD fields), valido, actualizado,
//   error.
// Handshake: ready is a level owned by the sequencer. Only its 0->1 edge
//   starts a check. After the check the block waits for ready to drop before
//   it accepts a new frame.
// Optional feature: define RTC_RANGO_CHECK_EN to add per-field range limits
//   on top of the per-nibble BCD check.
// Debug: the FSM state is held in state_q (type state_t).
module rtc_dato_captura #(
  parameter int W_DATO = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [W_DATO-1:0] bus_in,
  output logic [W_DATO-1:0] bus_out,
  input  logic              buffer_activo,
  output logic              bus_oe,
  input  logic              dir_com_cyt,
  input  logic              dir_seg,
  input  logic              dir_min,
  input  logic              dir_hora,
  input  logic              dir_dia,
  input  logic              dir_mes,
  input  logic              dir_anio,
  input  logic              dir_tseg,
  input  logic              dir_tmin,
  input  logic              dir_thora,
  input  logic              seg_in,
  input  logic              min_in,
  input  logic              hora_in,
  input  logic              dia_in,
  input  logic              mes_in,
  input  logic              anio_in,
  input  logic              tseg_in,
  input  logic              tmin_in,
  input  logic              thora_in,
  input  logic              ready,
  output logic [W_DATO-1:0] seg,
  output logic [W_DATO-1:0] min,
  output logic [W_DATO-1:0] hora,
  output logic [W_DATO-1:0] dia,
  output logic [W_DATO-1:0] mes,
  output logic [W_DATO-1:0] anio,
  output logic [W_DATO-1:0] tseg,
  output logic [W_DATO-1:0] tmin,
  output logic [W_DATO-1:0] thora,
  output logic              valido,
  output logic              actualizado,
  output logic              error
);

  localparam int NF = 9;

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_CHECK, S_WAIT} state_t;

  state_t state_q, state_d;

  // Field index order: seg, min, hora, dia, mes, anio, tseg, tmin, thora.
  logic [NF-1:0] strobe;
  logic [9:0]    dir_sel;
  logic          dir_multi;
  logic          strobe_multi;
  logic          ready_rise;
  logic          frame_ok;

  logic [NF-1:0]     strobe_q;
  logic              ready_q;
  logic [NF-1:0]     flags_q, flags_d;
  logic              conflict_q, conflict_d;
  logic [W_DATO-1:0] shadow_q [NF];
  logic [W_DATO-1:0] shadow_d [NF];
  logic [W_DATO-1:0] field_q [NF];
  logic [W_DATO-1:0] field_d [NF];
  logic              valido_q, valido_d;
  logic              actualizado_q, actualizado_d;
  logic              error_q, error_d;

  assign strobe  = {thora_in, tmin_in, tseg_in, anio_in, mes_in, dia_in,
                    hora_in, min_in, seg_in};
  assign dir_sel = {dir_thora, dir_tmin, dir_tseg, dir_anio, dir_mes, dir_dia,
                    dir_hora, dir_min, dir_seg, dir_com_cyt};

  // x & (x-1) is non-zero exactly when two or more bits are set.
  assign dir_multi    = |(dir_sel & (dir_sel - 10'd1));
  assign strobe_multi = |(strobe & (strobe - 9'd1));
  assign ready_rise   = ready & ~ready_q;
  assign bus_oe       = buffer_activo;

  // When no conflict is present at most one select is high, so the
  // priority order of this chain does not matter.
  always_comb begin
    bus_out = '0;
    if (!dir_multi) begin
      if      (dir_com_cyt) bus_out = W_DATO'(8'hF0);
      else if (dir_seg)     bus_out = W_DATO'(8'h21);
      else if (dir_min)     bus_out = W_DATO'(8'h22);
      else if (dir_hora)    bus_out = W_DATO'(8'h23);
      else if (dir_dia)     bus_out = W_DATO'(8'h24);
      else if (dir_mes)     bus_out = W_DATO'(8'h25);
      else if (dir_anio)    bus_out = W_DATO'(8'h26);
      else if (dir_tseg)    bus_out = W_DATO'(8'h41);
      else if (dir_tmin)    bus_out = W_DATO'(8'h42);
      else if (dir_thora)   bus_out = W_DATO'(8'h43);
    end
  end

  function automatic logic field_ok(input int idx, input logic [W_DATO-1:0] v);
    logic [7:0] b;
    logic       ok;
    b  = v[7:0];
    ok = (b[3:0] <= 4'd9) && (b[7:4] <= 4'd9);
`ifdef RTC_RANGO_CHECK_EN
    case (idx)
      0, 1, 6, 7: ok = ok && (b <= 8'h59);
      2, 8:       ok = ok && (b <= 8'h23);
      3:          ok = ok && (b >= 8'h01) && (b <= 8'h31);
      4:          ok = ok && (b >= 8'h01) && (b <= 8'h12);
      default:    ok = ok && (b <= 8'h99);
    endcase
`else
    if (idx < 0) ok = 1'b0;
`endif
    return ok;
  endfunction

  always_comb begin
    frame_ok = (&flags_q) && !conflict_q;
    for (int i = 0; i < NF; i++) begin
      frame_ok = frame_ok && field_ok(i, shadow_q[i]);
    end
  end

  always_comb begin
    state_d       = state_q;
    flags_d       = flags_q;
    conflict_d    = conflict_q;
    shadow_d      = shadow_q;
    field_d       = field_q;
    valido_d      = valido_q;
    actualizado_d = 1'b0;
    error_d       = 1'b0;

    // Capture also runs in IDLE so the first strobe cycle of a frame,
    // which is what moves the FSM to COLLECT, is not lost.
    if ((state_q == S_IDLE || state_q == S_COLLECT) && !strobe_multi) begin
      for (int i = 0; i < NF; i++) begin
        if (strobe[i]) shadow_d[i] = bus_in;
      end
    end

    if (state_q != S_CHECK && (strobe_multi || dir_multi)) conflict_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        flags_d = '0;
        if (ready_rise)                  state_d = S_CHECK;
        else if (|strobe || dir_com_cyt) state_d = S_COLLECT;
      end
      S_COLLECT: begin
        // A strobe falling in the ready-rise cycle still lands in this frame.
        flags_d = flags_q | (strobe_q & ~strobe);
        if (ready_rise) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (frame_ok) begin
          field_d       = shadow_q;
          valido_d      = 1'b1;
          actualizado_d = 1'b1;
        end else begin
          error_d = 1'b1;
        end
        flags_d    = '0;
        conflict_d = 1'b0;
        state_d    = S_WAIT;
      end
      default: begin
        if (!ready) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      strobe_q      <= '0;
      ready_q       <= 1'b0;
      flags_q       <= '0;
      conflict_q    <= 1'b0;
      valido_q      <= 1'b0;
      actualizado_q <= 1'b0;
      error_q       <= 1'b0;
      for (int i = 0; i < NF; i++) begin
        shadow_q[i] <= '0;
        field_q[i]  <= '0;
      end
    end else begin
      state_q       <= state_d;
      strobe_q      <= strobe;
      ready_q       <= ready;
      flags_q       <= flags_d;
      conflict_q    <= conflict_d;
      valido_q      <= valido_d;
      actualizado_q <= actualizado_d;
      error_q       <= error_d;
      shadow_q      <= shadow_d;
      field_q       <= field_d;
    end
  end

  assign seg         = field_q[0];
  assign min         = field_q[1];
  assign hora        = field_q[2];
  assign dia         = field_q[3];
  assign mes         = field_q[4];
  assign anio        = field_q[5];
  assign tseg        = field_q[6];
  assign tmin        = field_q[7];
  assign thora       = field_q[8];
  assign valido      = valido_q;
  assign actualizado = actualizado_q;
  assign error       = error_q;

endmodule

// File: tb/tb_rtc_dato_captura.sv
module tb_rtc_dato_captura;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] bus_in;
  logic [7:0] bus_out;
  logic       buffer_activo;
  logic       bus_oe;
  logic       ready;
  logic [9:0] dsel;
  logic [8:0] strb;
  logic [7:0] seg, min, hora, dia, mes, anio, tseg, tmin, thora;
  logic       valido, actualizado, error;
  logic [7:0] fo [9];

  int checks   = 0;
  int failures = 0;

  // Reference model: what the sequencer has delivered in the current frame,
  // and what the committed outputs should be.
  logic [7:0] exp_f [9];
  bit         exp_valido;
  logic [7:0] cap_v [9];
  bit         cap_f [9];
  bit         cap_conf;
  logic [7:0] exp_q [$];

  typedef struct {
    logic [9:0] sel;
    logic [7:0] bus;
  } dec_vec_t;
  dec_vec_t dec_tab [13];

  rtc_dato_captura #(.W_DATO(8)) dut (
    .clk(clk), .reset(reset), .bus_in(bus_in), .bus_out(bus_out),
    .buffer_activo(buffer_activo), .bus_oe(bus_oe),
    .dir_com_cyt(dsel[0]), .dir_seg(dsel[1]), .dir_min(dsel[2]),
    .dir_hora(dsel[3]), .dir_dia(dsel[4]), .dir_mes(dsel[5]),
    .dir_anio(dsel[6]), .dir_tseg(dsel[7]), .dir_tmin(dsel[8]),
    .dir_thora(dsel[9]),
    .seg_in(strb[0]), .min_in(strb[1]), .hora_in(strb[2]), .dia_in(strb[3]),
    .mes_in(strb[4]), .anio_in(strb[5]), .tseg_in(strb[6]), .tmin_in(strb[7]),
    .thora_in(strb[8]),
    .ready(ready),
    .seg(seg), .min(min), .hora(hora), .dia(dia), .mes(mes), .anio(anio),
    .tseg(tseg), .tmin(tmin), .thora(thora),
    .valido(valido), .actualizado(actualizado), .error(error)
  );

  assign fo[0] = seg;  assign fo[1] = min;  assign fo[2] = hora;
  assign fo[3] = dia;  assign fo[4] = mes;  assign fo[5] = anio;
  assign fo[6] = tseg; assign fo[7] = tmin; assign fo[8] = thora;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Decimal view of a BCD byte, used for validity and range checks.
  function automatic bit field_valid(input int idx, input logic [7:0] v);
    int hi, lo, d;
    hi = v / 16;
    lo = v % 16;
    if (hi > 9 || lo > 9) return 1'b0;
    d = hi * 10 + lo;
`ifdef RTC_RANGO_CHECK_EN
    if (idx == 0 || idx == 1 || idx == 6 || idx == 7) return d <= 59;
    if (idx == 2 || idx == 8) return d <= 23;
    if (idx == 3) return d >= 1 && d <= 31;
    if (idx == 4) return d >= 1 && d <= 12;
`endif
    return d <= 99;
  endfunction

  function automatic logic [7:0] make_bcd(input int lo, input int hi);
    int n;
    n = $urandom_range(hi, lo);
    return 8'((n / 10) * 16 + (n % 10));
  endfunction

  function automatic logic [7:0] rand_field(input int idx);
    case (idx)
      0, 1, 6, 7: return make_bcd(0, 59);
      2, 8:       return make_bcd(0, 23);
      3:          return make_bcd(1, 31);
      4:          return make_bcd(1, 12);
      default:    return make_bcd(0, 99);
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 9; i++) begin
      exp_f[i] = 8'h00;
      cap_f[i] = 1'b0;
      cap_v[i] = 8'h00;
    end
    exp_valido = 1'b0;
    cap_conf   = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_field(input int idx, input logic [7:0] v, input int hold);
    for (int c = 0; c < hold; c++) begin
      strb      = '0;
      strb[idx] = 1'b1;
      bus_in    = (c == hold - 1) ? v : 8'($urandom);
      step();
    end
    strb       = '0;
    cap_v[idx] = v;
    cap_f[idx] = 1'b1;
  endtask

  task automatic gap(input int n);
    strb = '0;
    for (int c = 0; c < n; c++) begin
      bus_in = 8'($urandom);
      step();
    end
  endtask

  task automatic full_frame(input logic [8:0][7:0] v, input logic [8:0] skip);
    for (int i = 0; i < 9; i++) begin
      if (!skip[i]) drive_field(i, v[i], 1);
    end
  endtask

  // Raise ready (the last strobe falls in the same cycle), then score the
  // result two cycles later and let the block return to idle.
  task automatic finish_frame(input string tag);
    bit ok;
    ok = !cap_conf;
    for (int i = 0; i < 9; i++) ok = ok && cap_f[i] && field_valid(i, cap_v[i]);
    strb  = '0;
    ready = 1'b1;
    step();
    step();
    if (ok) begin
      for (int i = 0; i < 9; i++) exp_f[i] = cap_v[i];
      exp_valido = 1'b1;
    end
    chk({tag, "_actualizado"}, actualizado, ok);
    chk({tag, "_error"}, error, !ok);
    chk({tag, "_valido"}, valido, exp_valido);
    for (int i = 0; i < 9; i++) exp_q.push_back(exp_f[i]);
    for (int i = 0; i < 9; i++) chk($sformatf("%s_f%0d", tag, i), fo[i], exp_q.pop_front());
    ready = 1'b0;
    step();
    chk({tag, "_pulse_end"}, {actualizado, error}, 2'b00);
    step();
    for (int i = 0; i < 9; i++) cap_f[i] = 1'b0;
    cap_conf = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [8:0][7:0] base;
  logic [8:0][7:0] v;
  int order [9];

  initial begin
    base = {8'h01, 8'h05, 8'h10, 8'h24, 8'h06, 8'h15, 8'h12, 8'h30, 8'h45};
    dec_tab[0]  = '{10'b00_0000_0000, 8'h00};
    dec_tab[1]  = '{10'b00_0000_0001, 8'hF0};
    dec_tab[2]  = '{10'b00_0000_0010, 8'h21};
    dec_tab[3]  = '{10'b00_0000_0100, 8'h22};
    dec_tab[4]  = '{10'b00_0000_1000, 8'h23};
    dec_tab[5]  = '{10'b00_0001_0000, 8'h24};
    dec_tab[6]  = '{10'b00_0010_0000, 8'h25};
    dec_tab[7]  = '{10'b00_0100_0000, 8'h26};
    dec_tab[8]  = '{10'b00_1000_0000, 8'h41};
    dec_tab[9]  = '{10'b01_0000_0000, 8'h42};
    dec_tab[10] = '{10'b10_0000_0000, 8'h43};
    dec_tab[11] = '{10'b00_0000_0110, 8'h00};
    dec_tab[12] = '{10'b10_0000_0001, 8'h00};

    reset = 1'b1; bus_in = 8'h00; buffer_activo = 1'b1; ready = 1'b0;
    dsel = '0; strb = '0;
    model_reset();
    step(); step();
    for (int i = 0; i < 9; i++) chk($sformatf("rst_f%0d", i), fo[i], 8'h00);
    chk("rst_flags", {valido, actualizado, error}, 3'b000);
    chk("rst_bus_out", bus_out, 8'h00);
    chk("rst_bus_oe", bus_oe, 1'b1);
    reset = 1'b0;
    step();

    // Address decode table; the conflicting entries taint the next frame.
    for (int k = 0; k < 13; k++) begin
      dsel = dec_tab[k].sel;
      buffer_activo = 1'($urandom);
      #1;
      chk($sformatf("dec%0d_bus_out", k), bus_out, dec_tab[k].bus);
      chk($sformatf("dec%0d_bus_oe", k), bus_oe, buffer_activo);
      step();
      if (k >= 11) cap_conf = 1'b1;
    end
    dsel = '0;
    full_frame(base, 9'h000);
    finish_frame("dir_conflict");

    full_frame(base, 9'h000);
    finish_frame("full");

    full_frame(base, 9'h020);
    finish_frame("missing_anio");

    v = base; v[0] = 8'h4A;
    full_frame(v, 9'h000);
    finish_frame("bad_bcd");

    v = base; v[4] = 8'h13;
    full_frame(v, 9'h000);
    finish_frame("mes13");

    // Held strobe: last value of the high window is the one kept.
    for (int c = 0; c < 4; c++) begin
      strb = 9'h001;
      bus_in = 8'((c + 1) * 8'h11);
      step();
    end
    strb = '0; cap_v[0] = 8'h44; cap_f[0] = 1'b1;
    full_frame(base, 9'h001);
    finish_frame("held");
    chk("held_seg", seg, 8'h44);

    // Two data strobes in one cycle reject the frame.
    full_frame(base, 9'h000);
    strb = 9'h003; bus_in = 8'h99; step(); strb = '0;
    cap_conf = 1'b1;
    finish_frame("strobe_conflict");

    finish_frame("empty");

    // Mid-frame reset discards everything.
    full_frame(base, 9'h1E0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_reset();
    step();
    for (int i = 0; i < 9; i++) chk($sformatf("midrst_f%0d", i), fo[i], 8'h00);
    chk("midrst_valido", valido, 1'b0);
    full_frame(base, 9'h000);
    finish_frame("after_reset");

    // Randomized frames: random order, hold lengths, gaps, bad values, skips.
    for (int f = 0; f < 25; f++) begin
      int bad_idx, skip_idx;
      for (int i = 0; i < 9; i++) begin
        v[i] = rand_field(i);
        order[i] = i;
      end
      bad_idx  = ($urandom_range(3, 0) == 0) ? int'($urandom_range(8, 0)) : -1;
      skip_idx = ($urandom_range(5, 0) == 0) ? int'($urandom_range(8, 0)) : -1;
      if (bad_idx >= 0) v[bad_idx] = 8'($urandom);
      for (int i = 8; i > 0; i--) begin
        int j, t;
        j = $urandom_range(i, 0);
        t = order[i]; order[i] = order[j]; order[j] = t;
      end
      for (int k = 0; k < 9; k++) begin
        if (order[k] != skip_idx) begin
          drive_field(order[k], v[order[k]], $urandom_range(3, 1));
          gap($urandom_range(2, 0));
        end
      end
      finish_frame($sformatf("rnd%0d", f));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
